seq_con_unit: RTL and testbench

- Parametrised, sequenced successor to the combinational control-signal decoder of the small computer.
- Decodes the opcode field of the IR itself, so no external one-hot instruction lines are needed.
- Owns a FETCH/EXEC/POP_WB/HALT state machine, an internal stack pointer with overflow/underflow detection, stalling I/O handshakes, and HALT/resume.
- Sits between the IR and the datapath: drives PC, RAM, register file, ALU, flag, I/O and stack-RAM controls.

---
 rtl/seq_con_unit.sv | 148 ++++++++++++++
 tb/tb_seq_con_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_con_unit.sv
// Sequenced control unit: decodes the IR opcode, runs a FETCH/EXEC/POP_WB/HALT
// machine and keeps an internal stack pointer with sticky overflow/underflow.
module seq_con_unit #(
  parameter int RSEL_W      = 2,
  parameter int IR_W        = 4 + 2 * RSEL_W,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   ir,
  input  logic              g,
  input  logic              in_vld,
  input  logic              out_rdy,
  input  logic              run,
  output logic              ir_ld,
  output logic              ram_re,
  output logic              ram_wr,
  output logic              pc_ld,
  output logic              pc_in,
  output logic              reg_we,
  output logic              au_en,
  output logic              gf_en,
  output logic              in_en,
  output logic              out_en,
  output logic              mux_s,
  output logic              swr,
  output logic              sre,
  output logic [RSEL_W-1:0] reg_sr,
  output logic [RSEL_W-1:0] reg_dr,
  output logic [1:0]        s,
  output logic [3:0]        au_ac,
  output logic [SP_W-1:0]   stk_addr,
  output logic [SP_W:0]     sp,
  output logic              stk_err,
  output logic              halted
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_POP_WB, ST_HALT} state_t;

  localparam logic [SP_W:0] DEPTH = (SP_W + 1)'(STACK_DEPTH);

  state_t          r_state;
  logic [SP_W:0]   r_sp;
  logic            r_stk_err;

  state_t          w_state_nx;
  logic [SP_W:0]   w_sp_nx;
  logic            w_err_nx;
  logic [SP_W:0]   w_sp_m1;
  logic [3:0]      w_op;

  assign w_op    = ir[IR_W-1:IR_W-4];
  assign w_sp_m1 = r_sp - 1'b1;
  assign au_ac   = w_op;
  assign reg_sr  = ir[RSEL_W-1:0];
  assign reg_dr  = ir[2*RSEL_W-1:RSEL_W];
  assign sp      = r_sp;
  assign stk_err = r_stk_err;
  assign halted  = (r_state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sp      <= w_sp_nx;
      r_stk_err <= w_err_nx;
    end
  end

  always_comb begin
    ir_ld = 1'b0; ram_re = 1'b0; ram_wr = 1'b0; pc_ld = 1'b0; pc_in = 1'b0;
    reg_we = 1'b0; au_en = 1'b0; gf_en = 1'b0; in_en = 1'b0; out_en = 1'b0;
    mux_s = 1'b0; swr = 1'b0; sre = 1'b0; s = 2'b00; stk_addr = '0;
    w_state_nx = r_state;
    w_sp_nx    = r_sp;
    w_err_nx   = r_stk_err;
    case (r_state)
      ST_FETCH: begin
        ir_ld = 1'b1; ram_re = 1'b1; pc_in = 1'b1;
        w_state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nx = ST_FETCH;
        case (w_op)
          4'h1: begin au_en = 1'b1; reg_we = 1'b1; mux_s = 1'b1; end
          4'h2: begin au_en = 1'b1; ram_wr = 1'b1; s = 2'b10; end
          4'h3: begin ram_re = 1'b1; reg_we = 1'b1; mux_s = 1'b1; s = 2'b01; end
          4'h4: reg_we = 1'b1;
          4'h5: begin au_en = 1'b1; reg_we = 1'b1; mux_s = 1'b1; end
          4'h6: begin au_en = 1'b1; reg_we = 1'b1; mux_s = 1'b1; gf_en = 1'b1; end
          4'h7: pc_ld = 1'b1;
          4'h8: pc_ld = g;
          4'h9: begin
            in_en = 1'b1;
            if (in_vld) begin
              reg_we = 1'b1; mux_s = 1'b1;
            end else begin
              w_state_nx = ST_EXEC;
            end
          end
          4'hA: begin
            au_en = 1'b1; out_en = 1'b1;
            if (!out_rdy) w_state_nx = ST_EXEC;
          end
          4'hB: begin ram_re = 1'b1; pc_in = 1'b1; reg_we = 1'b1; mux_s = 1'b1; end
          4'hC: begin
            if (r_sp < DEPTH) begin
              au_en = 1'b1; swr = 1'b1; stk_addr = r_sp[SP_W-1:0];
              w_sp_nx = r_sp + 1'b1;
            end else begin
              w_err_nx = 1'b1;
            end
          end
          4'hD: begin
            // Stack RAM answers one cycle later, so the write-back lives in POP_WB
            if (r_sp != '0) begin
              sre = 1'b1; stk_addr = w_sp_m1[SP_W-1:0];
              w_sp_nx = w_sp_m1;
              w_state_nx = ST_POP_WB;
            end else begin
              w_err_nx = 1'b1;
            end
          end
          4'hF: w_state_nx = ST_HALT;
          default: ;
        endcase
      end
      ST_POP_WB: begin
        reg_we = 1'b1; mux_s = 1'b1;
        w_state_nx = ST_FETCH;
      end
      ST_HALT: begin
        if (run) w_state_nx = ST_FETCH;
      end
      default: w_state_nx = ST_FETCH;
    endcase
    if (rst) begin
      ir_ld = 1'b0; ram_re = 1'b0; ram_wr = 1'b0; pc_ld = 1'b0; pc_in = 1'b0;
      reg_we = 1'b0; au_en = 1'b0; gf_en = 1'b0; in_en = 1'b0; out_en = 1'b0;
      mux_s = 1'b0; swr = 1'b0; sre = 1'b0; s = 2'b00; stk_addr = '0;
    end
  end

endmodule

// File: tb/tb_seq_con_unit.sv
// Directed bench for seq_con_unit: walks the instruction sequences of the test
// plan cycle by cycle against hand-computed strobe patterns.
module tb_seq_con_unit;

  logic       clk = 1'b0;
  logic       rst, g, in_vld, out_rdy, run;
  logic [7:0] ir;
  logic       ir_ld, ram_re, ram_wr, pc_ld, pc_in, reg_we, au_en, gf_en;
  logic       in_en, out_en, mux_s, swr, sre, stk_err, halted;
  logic [1:0] reg_sr, reg_dr, s;
  logic [3:0] au_ac, stk_addr;
  logic [4:0] sp;

  int n_chk = 0;
  int n_pass = 0;

  // Strobe vector order: ir_ld ram_re ram_wr pc_ld pc_in reg_we au_en gf_en in_en out_en mux_s swr sre
  localparam logic [12:0] S_NONE  = 13'b0000000000000;
  localparam logic [12:0] S_FETCH = 13'b1100100000000;
  localparam logic [12:0] S_ADD   = 13'b0000011000100;
  localparam logic [12:0] S_JMP   = 13'b0001000000000;
  localparam logic [12:0] S_INW   = 13'b0000000010000;
  localparam logic [12:0] S_IND   = 13'b0000010010100;
  localparam logic [12:0] S_OUT   = 13'b0000001001000;
  localparam logic [12:0] S_PUSH  = 13'b0000001000010;
  localparam logic [12:0] S_POP   = 13'b0000000000001;
  localparam logic [12:0] S_POPWB = 13'b0000010000100;

  logic [12:0] w_stb;
  assign w_stb = {ir_ld, ram_re, ram_wr, pc_ld, pc_in, reg_we, au_en, gf_en,
                  in_en, out_en, mux_s, swr, sre};

  seq_con_unit #(.RSEL_W(2), .IR_W(8), .STACK_DEPTH(16), .SP_W(4)) u_dut (
    .clk(clk), .rst(rst), .ir(ir), .g(g), .in_vld(in_vld), .out_rdy(out_rdy),
    .run(run), .ir_ld(ir_ld), .ram_re(ram_re), .ram_wr(ram_wr), .pc_ld(pc_ld),
    .pc_in(pc_in), .reg_we(reg_we), .au_en(au_en), .gf_en(gf_en), .in_en(in_en),
    .out_en(out_en), .mux_s(mux_s), .swr(swr), .sre(sre), .reg_sr(reg_sr),
    .reg_dr(reg_dr), .s(s), .au_ac(au_ac), .stk_addr(stk_addr), .sp(sp),
    .stk_err(stk_err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ir = 8'h00; g = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; run = 1'b0;
    tick();
    check("rst_strobes", 32'(w_stb), 32'(S_NONE));
    check("rst_s_addr", 32'({s, stk_addr}), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_fetch", 32'(w_stb), 32'(S_FETCH));
    check("post_rst_sp", 32'(sp), 32'd0);
    check("post_rst_err", 32'(stk_err), 32'd0);
    check("post_rst_halted", 32'(halted), 32'd0);

    // ADD r0,r1
    ir = 8'h51;
    tick();
    check("add_exec", 32'(w_stb), 32'(S_ADD));
    check("add_fields", 32'({au_ac, reg_dr, reg_sr}), 32'({4'd5, 2'd0, 2'd1}));
    tick();
    check("add_back_fetch", 32'(w_stb), 32'(S_FETCH));

    // JG with g=0 then g=1
    ir = 8'h80; g = 1'b0;
    tick();
    check("jg0_exec", 32'(w_stb), 32'(S_NONE));
    tick();
    check("jg0_fetch", 32'(w_stb), 32'(S_FETCH));
    g = 1'b1;
    tick();
    check("jg1_exec", 32'(w_stb), 32'(S_JMP));
    tick();
    check("jg1_fetch", 32'(w_stb), 32'(S_FETCH));
    g = 1'b0;

    // IN r1 with three stalled cycles
    ir = 8'h94; in_vld = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("in_wait", 32'(w_stb), 32'(S_INW));
      tick();
    end
    in_vld = 1'b1;
    #1;
    check("in_done", 32'(w_stb), 32'(S_IND));
    check("in_dr", 32'(reg_dr), 32'd1);
    tick();
    in_vld = 1'b0;
    check("in_fetch", 32'(w_stb), 32'(S_FETCH));

    // Fill the stack, then one push too many
    ir = 8'hC0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("push_stb", 32'(w_stb), 32'(S_PUSH));
      check("push_addr", 32'(stk_addr), i);
      tick();
      check("push_sp", 32'(sp), i + 1);
    end
    check("push_full_err", 32'(stk_err), 32'd0);
    tick();
    check("push_ovf_stb", 32'(w_stb), 32'(S_NONE));
    tick();
    check("push_ovf_err", 32'(stk_err), 32'd1);
    check("push_ovf_sp", 32'(sp), 32'd16);

    // Drain the stack, then one pop too many
    ir = 8'hD0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("pop_stb", 32'(w_stb), 32'(S_POP));
      check("pop_addr", 32'(stk_addr), 15 - i);
      tick();
      check("popwb_stb", 32'(w_stb), 32'(S_POPWB));
      check("popwb_sp", 32'(sp), 15 - i);
      tick();
    end
    check("pop_empty_sp", 32'(sp), 32'd0);
    tick();
    check("pop_unf_stb", 32'(w_stb), 32'(S_NONE));
    tick();
    check("pop_unf_fetch", 32'(w_stb), 32'(S_FETCH));

    // HALT and resume
    ir = 8'hF0;
    tick();
    check("halt_exec", 32'(w_stb), 32'(S_NONE));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_stb", 32'(w_stb), 32'(S_NONE));
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    check("resume_fetch", 32'(w_stb), 32'(S_FETCH));
    check("resume_halted", 32'(halted), 32'd0);

    // run is ignored outside HALT: EXEC of a NOP with run high still goes to FETCH
    ir = 8'h00;
    tick();
    run = 1'b1;
    #1;
    check("nop_exec", 32'(w_stb), 32'(S_NONE));
    tick();
    run = 1'b0;
    check("nop_fetch", 32'(w_stb), 32'(S_FETCH));

    // OUT stalled, then reset mid-stall
    ir = 8'hA0; out_rdy = 1'b0;
    tick();
    check("out_stall1", 32'(w_stb), 32'(S_OUT));
    tick();
    check("out_stall2", 32'(w_stb), 32'(S_OUT));
    rst = 1'b1;
    #1;
    check("out_rst_stb", 32'(w_stb), 32'(S_NONE));
    tick();
    rst = 1'b0;
    #1;
    check("out_rst_fetch", 32'(w_stb), 32'(S_FETCH));
    check("out_rst_sp", 32'(sp), 32'd0);
    check("out_rst_err", 32'(stk_err), 32'd0);

    // OUT completing when the device is ready
    out_rdy = 1'b1;
    tick();
    check("out_ready", 32'(w_stb), 32'(S_OUT));
    tick();
    check("out_fetch", 32'(w_stb), 32'(S_FETCH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
